// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 write initiator for the register-programming
// interface. It accepts a 4-bit address / 8-bit data write command over a
// valid/ready handshake and sends it as one 16-bit frame
// {1'b1, 3'b000, addr, data}, MSB first. SCLK is clk divided by 2*CLK_DIV.
// A command whose address is above 4 is rejected with a one-cycle err pulse.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready only while idle
//   cmd_addr, cmd_data   command fields, latched on acceptance
//   busy                 inverse of cmd_ready
//   done                 one-cycle pulse as nCS rises at the end of a frame
//   err                  one-cycle pulse when a command is rejected
//   nCS, SCLK, COPI      serial bus (registered)
module spi_controller #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(CS_GAP - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam logic [3:0] MAX_ADDR = 4'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;
  logic          cnt_zero;

  assign cnt_zero  = (cnt == '0);
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  // Bus outputs are driven with the values of the state being entered, so
  // they change on the same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      nCS     <= 1'b1;
      SCLK    <= 1'b0;
      COPI    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr > MAX_ADDR) begin
              err <= 1'b1;
            end else begin
              shreg <= {1'b1, 3'b000, cmd_addr, cmd_data};
              COPI  <= 1'b1;
              nCS   <= 1'b0;
              cnt   <= DIV_LOAD;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            SCLK    <= 1'b1;
            cnt     <= DIV_LOAD;
            bit_cnt <= 4'd15;
            state   <= SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_zero) begin
            cnt <= DIV_LOAD;
            if (SCLK) begin
              SCLK <= 1'b0;
              if (bit_cnt == 4'd0) begin
                // Last falling edge: COPI keeps bit 0 through HOLD.
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
                shreg   <= {shreg[14:0], 1'b0};
                COPI    <= shreg[14];
              end
            end else begin
              SCLK <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            nCS   <= 1'b1;
            COPI  <= 1'b0;
            done  <= 1'b1;
            cnt   <= GAP_LOAD;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          nCS   <= 1'b1;
          SCLK  <= 1'b0;
          COPI  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Testbench for spi_controller (CLK_DIV=4, CS_GAP=8). A bus monitor captures
// frames on SCLK rises and models a five-register SPI write peripheral.
module tb_spi_controller;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CS_GAP  = 8;
  localparam int unsigned NCS_LOW = 33 * CLK_DIV;
  localparam int unsigned LAT     = 1 + 33 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, busy, done, err, nCS, SCLK, COPI;

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done),
    .err(err), .nCS(nCS), .SCLK(SCLK), .COPI(COPI)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bus monitor / peripheral model ----------------
  typedef struct {
    logic [15:0] word;
    int unsigned rises;
    int unsigned low;
    int unsigned first_rise;
  } frame_t;

  frame_t      fq[$];
  logic [7:0]  regs[5] = '{default: 8'h00};
  logic        prev_sclk = 1'b0, prev_ncs = 1'b1, prev_copi = 1'b0;
  logic [15:0] cap = '0;
  int unsigned rises = 0, low_len = 0, hi_len = 0, last_gap = 0, first_rise = 0;
  int unsigned done_cnt = 0, err_cnt = 0, last_done_cyc = 0, last_err_cyc = 0;
  int unsigned ncs_falls = 0, sclk_rises_total = 0, copi_viol = 0;

  always @(negedge clk) begin
    if (!nCS && prev_ncs) begin
      cap = '0; rises = 0; low_len = 0; ncs_falls++;
      last_gap = hi_len; hi_len = 0;
    end
    if (nCS) hi_len++;
    else low_len++;
    if (SCLK && !prev_sclk) begin
      sclk_rises_total++;
      if (!nCS) begin
        rises++;
        if (rises == 1) first_rise = cyc;
        cap = {cap[14:0], COPI};
      end
    end
    if (!nCS && !prev_ncs && (COPI != prev_copi) && !(!SCLK && prev_sclk))
      copi_viol++;
    if (nCS && !prev_ncs) begin
      fq.push_back('{word: cap, rises: rises, low: low_len, first_rise: first_rise});
      if (rises == 16 && cap[15] && cap[11:8] <= 4'd4)
        regs[cap[10:8]] = cap[7:0];
    end
    if (done) begin done_cnt++; last_done_cyc = cyc; end
    if (err)  begin err_cnt++;  last_err_cyc  = cyc; end
    prev_sclk = SCLK; prev_ncs = nCS; prev_copi = COPI;
  end

  // ---------------- helpers ----------------
  task automatic wait_ready(output int unsigned t);
    bit seen = 0;
    t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (cmd_ready) begin seen = 1; t = cyc; break; end
    end
    if (!seen) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input int unsigned d0);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin seen = 1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_word,
                             input int unsigned t_acc);
    frame_t fr;
    chk({tag, "_fq_size"}, fq.size(), 1);
    if (fq.size() != 0) begin
      fr = fq.pop_front();
      chk({tag, "_word"}, fr.word, exp_word);
      chk({tag, "_rises"}, fr.rises, 16);
      chk({tag, "_ncs_low"}, fr.low, NCS_LOW);
      chk({tag, "_first_rise"}, fr.first_rise - t_acc, 1 + CLK_DIV);
    end
  endtask

  task automatic run_vec(input string tag, input logic [3:0] a, input logic [7:0] d,
                         input bit exp_err, input logic [15:0] exp_word);
    int unsigned t, tr, d0, e0, f0, s0;
    d0 = done_cnt; e0 = err_cnt; f0 = ncs_falls; s0 = sclk_rises_total;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    wait_ready(t);
    @(posedge clk); #1;
    // scramble inputs after acceptance: the controller must use latched fields
    cmd_valid = 1'b0; cmd_addr = ~a; cmd_data = ~d;
    if (exp_err) begin
      @(negedge clk); #1;
      chk({tag, "_err_cnt"}, err_cnt, e0 + 1);
      chk({tag, "_err_time"}, last_err_cyc - t, 1);
      chk({tag, "_ready_after_err"}, cmd_ready, 1);
      repeat (20) @(negedge clk);
      #1;
      chk({tag, "_no_ncs"}, ncs_falls, f0);
      chk({tag, "_no_sclk"}, sclk_rises_total, s0);
      chk({tag, "_no_done"}, done_cnt, d0);
      chk({tag, "_err_once"}, err_cnt, e0 + 1);
      chk({tag, "_ready_idle"}, cmd_ready, 1);
    end else begin
      wait_done(d0);
      chk({tag, "_latency"}, last_done_cyc - t, LAT);
      check_frame(tag, exp_word, t);
      wait_ready(tr);
      chk({tag, "_ready_gap"}, tr - last_done_cyc, CS_GAP);
      chk({tag, "_done_once"}, done_cnt, d0 + 1);
      chk({tag, "_no_err"}, err_cnt, e0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  data;
    bit          exp_err;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int unsigned t1, t2, t_rst, d0;
    frame_t fr;

    vecs[0] = '{4'd2,  8'hA5, 1'b0, 16'h82A5};
    vecs[1] = '{4'd0,  8'h01, 1'b0, 16'h8001};
    vecs[2] = '{4'd1,  8'h02, 1'b0, 16'h8102};
    vecs[3] = '{4'd2,  8'h04, 1'b0, 16'h8204};
    vecs[4] = '{4'd3,  8'h08, 1'b0, 16'h8308};
    vecs[5] = '{4'd4,  8'h10, 1'b0, 16'h8410};
    vecs[6] = '{4'd7,  8'h11, 1'b1, 16'h0000};
    vecs[7] = '{4'd5,  8'hEE, 1'b1, 16'h0000};
    vecs[8] = '{4'd15, 8'hFF, 1'b1, 16'h0000};

    // reset values, during and after reset
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ncs", nCS, 1);
    chk("rst_in_sclk", SCLK, 0);
    @(negedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_ncs", nCS, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_copi", COPI, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // back-to-back with cmd_valid held high
    d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_data = 8'hFF;
    wait_ready(t1);
    @(posedge clk); #1;
    cmd_addr = 4'd4; cmd_data = 8'h3C;
    chk("b2b_busy", busy, 1);
    wait_ready(t2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_second_accept", t2 - last_done_cyc, CS_GAP);
    chk("b2b_period", t2 - t1, 1 + 33 * CLK_DIV + CS_GAP);
    check_frame("b2b_f1", 16'h80FF, t1);
    wait_done(d0 + 1);
    check_frame("b2b_f2", 16'h843C, t2);
    chk("b2b_ncs_gap", last_gap, CS_GAP + 1);
    chk("b2b_done_cnt", done_cnt, d0 + 2);
    begin
      int unsigned tr;
      wait_ready(tr);
    end

    // reset in the middle of a frame
    d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 4'd3; cmd_data = 8'hC3;
    wait_ready(t1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (!nCS && rises >= 5) begin seen = 1; break; end
      end
      if (!seen) chk("mid_rst_timeout", 0, 1);
    end
    chk("mid_rst_sclk_high", SCLK, 1);
    #2;
    t_rst = cyc;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async_edge", cyc, t_rst);
    chk("mid_rst_ncs", nCS, 1);
    chk("mid_rst_sclk", SCLK, 0);
    chk("mid_rst_copi", COPI, 0);
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_no_done", done_cnt, d0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_fq", fq.size(), 1);
    if (fq.size() != 0) begin
      fr = fq.pop_front();
      chk("mid_rst_rises", fr.rises, 5);
    end
    run_vec("post_rst", 4'd1, 8'h5A, 1'b0, 16'h815A);

    // table: single writes, loopback fills, rejected addresses
    for (int i = 0; i < 9; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data,
              vecs[i].exp_err, vecs[i].exp_word);

    // peripheral contents after loopback writes and ignored commands
    for (int i = 0; i < 5; i++)
      chk($sformatf("reg%0d", i), regs[i], 8'h01 << i);

    chk("copi_only_on_fall", copi_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI-mode-0 write initiator for the chip's register-programming interface. Accepts a register write command (4-bit address, 8-bit data) through a valid/ready handshake and serialises it as a single 16-bit frame on nCS/SCLK/COPI. SCLK is generated by dividing clk. Primary uses are driving the on-chip SPI register peripheral in loopback benches and bring-up, and programming external devices that use the same register map.

## Interface
Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period. Legal range 2..255. Use ≥4 when the target samples SCLK through a 3-flop synchroniser on the same clk.
- CS_GAP, 8, minimum clk cycles nCS stays high between frames. Legal range ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_addr  in  4  target register address; legal values are 0..4.
- cmd_data  in  8  write data.
- busy  out  1  equals ~cmd_ready.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse when a command is rejected.
- nCS  out  1  chip select, active low.
- SCLK  out  1  serial clock, idle low.
- COPI  out  1  serial data, MSB first.

## Operation
- Frame word: {1'b1, 3'b000, cmd_addr[3:0], cmd_data[7:0]}. Bit 15 is the write flag. Bits are shifted out MSB first.
- Mode 0:
  - The target samples COPI on SCLK rising.
  - COPI changes only on SCLK falling, or at frame start.
- A command is accepted when cmd_valid && cmd_ready. On acceptance the command fields are latched, so inputs may change afterwards.
- If the accepted cmd_addr > 4:
  - err pulses on the next cycle.
  - No frame is sent and nCS stays high.
  - The state stays IDLE; cmd_ready stays high.
- While busy, cmd_valid is ignored. The upstream must hold the command until it sees cmd_ready.
- All serial outputs and done/err are registered. cmd_ready/busy are decoded from the state.
- State machine: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
  - IDLE: nCS=1, SCLK=0, COPI=0. A valid accept moves to SETUP.
  - SETUP: nCS=0, SCLK=0, COPI=bit15. Lasts CLK_DIV cycles.
  - SHIFT: 16 SCLK high phases separated by 15 low phases, each CLK_DIV cycles. A 4-bit bit counter runs 15→0. On each falling edge except the last, COPI advances to the next bit.
  - HOLD: SCLK=0, nCS=0, COPI keeps bit0. Lasts CLK_DIV cycles.
  - GAP: nCS=1, COPI=0. Lasts CS_GAP cycles, then returns to IDLE.
- done pulses in the same cycle nCS rises, i.e. the first GAP cycle.
- Reset mid-frame:
  - Outputs return to reset values immediately (nCS high, SCLK low).
  - The frame is abandoned, with no done pulse.
  - After release the controller is in IDLE.

## Timing
- Reset values: nCS=1, SCLK=0, COPI=0, done=0, err=0, cmd_ready=1, busy=0.
- Accept at cycle T: nCS falls at T+1.
- First SCLK rise: T+1+CLK_DIV.
- nCS low duration: exactly 33·CLK_DIV cycles (SETUP + 16 high + 15 low + HOLD).
- SCLK high duration = low duration = CLK_DIV cycles.
- Setup/hold margin: COPI is stable ≥CLK_DIV cycles before and after every SCLK rise.
- Accept-to-done latency: 1 + 33·CLK_DIV cycles.
- cmd_ready re-asserts CS_GAP cycles after done.
- Back-to-back minimum period: 1 + 33·CLK_DIV + CS_GAP cycles. With defaults this is 141.
- Rejected command: err at T+1; the next command can be accepted at T+1.

## Test plan
- Reset: assert rst_n low, release → nCS=1, SCLK=0, COPI=0, cmd_ready=1, done=err=0.
- Single write, addr=2, data=0xA5 → bench samples COPI on SCLK rises and captures 0x82A5.
  - Exactly 16 SCLK rises.
  - nCS low for 132 cycles.
  - done pulses once, 133 cycles after accept.
- Back-to-back: (0,0xFF) then (4,0x3C) with cmd_valid held high → two frames 0x80FF and 0x843C.
  - nCS high ≥8 cycles between them.
  - The second accept occurs exactly 8 cycles after the first done.
- Invalid command, addr=7, data=0x11 → err pulses at T+1. nCS and SCLK never toggle, done stays low, cmd_ready stays high.
- Reset mid-frame: assert rst_n after the 5th SCLK rise of a write → nCS goes high asynchronously and SCLK goes low, with no done. A subsequent write (1,0x5A) produces a clean 0x815A frame.
- Loopback with the register peripheral (CLK_DIV=4): write addresses 0..4 with 0x01,0x02,0x04,0x08,0x10 → the peripheral registers read back those values. Ignored commands (addr 5..15) leave all registers unchanged.
